// File: rtl/diff_to_bcd_pkg.sv
// Package wrapper around the shared header.
// Other files import this package.
// Holds only types and constants, with no logic.
package diff_to_bcd_pkg;
  `include "diff_to_bcd_defs.svh"
endpackage

// File: rtl/diff_to_bcd_bcd_add3.sv
// Double-dabble nibble correction: adds 3 when the nibble is 5 or more.
// Latency: purely combinational.
// Backpressure: none.
module bcd_add3
  import diff_to_bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Correct the nibble so the following left shift carries into the next BCD digit
  always_comb begin
    dout = din;
    if (din >= BCD_ADD3_THRESH) begin
      dout = din + BCD_ADD3_VAL;
    end
  end

endmodule

// File: rtl/diff_to_bcd_defs.svh
// Shared FSM state encodings and the double-dabble correction constants.
// Pulled into diff_to_bcd_pkg so RTL and bench see one definition.
// Include-guarded so repeated inclusion is harmless.
`ifndef DIFF_TO_BCD_DEFS_SVH
`define DIFF_TO_BCD_DEFS_SVH

typedef enum logic [1:0] {
  ST_IDLE  = 2'd0,
  ST_SHIFT = 2'd1,
  ST_DONE  = 2'd2
} state_t;

// A nibble at or above this value gets the correction added before each shift.
localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;
localparam logic [3:0] BCD_ADD3_VAL    = 4'd3;

`endif

// File: rtl/diff_to_bcd.sv
// Converts a signed subtractor result to sign plus two BCD digits (double dabble).
// Latency: done pulses W+1 edges after the edge that samples start.
// Backpressure: start is ignored while busy; there is no request queue.
module diff_to_bcd
  import diff_to_bcd_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] diff,
  input  logic         overflow,
  output logic         busy,
  output logic         done,
  output logic         sign,
  output logic [3:0]   tens,
  output logic [3:0]   ones,
  output logic         err
);

  localparam int CW = $clog2(W + 1);
  localparam int SW = 8 + W;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sreg;
  logic          sign_cap;
  logic          err_cap;
  logic [W-1:0]  mag;
  logic [3:0]    tens_adj;
  logic [3:0]    ones_adj;
  logic [SW-1:0] sreg_adj;

  // -2^(W-1) negates to itself, which reads correctly as the unsigned 2^(W-1).
  assign mag = diff[W-1] ? (-diff) : diff;

  bcd_add3 u_tens_add3 (
    .din  (sreg[SW-1 -: 4]),
    .dout (tens_adj)
  );

  bcd_add3 u_ones_add3 (
    .din  (sreg[W+3 -: 4]),
    .dout (ones_adj)
  );

  assign sreg_adj = {tens_adj, ones_adj, sreg[W-1:0]};

  // The done-pulse cycle is treated as the tail of DONE, so a start there is also dropped.
  assign busy = (state != ST_IDLE) | done;

  // Conversion FSM: capture, W shift-and-correct steps, then register the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      sreg     <= '0;
      sign_cap <= 1'b0;
      err_cap  <= 1'b0;
      done     <= 1'b0;
      sign     <= 1'b0;
      tens     <= 4'd0;
      ones     <= 4'd0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !done) begin
            sign_cap <= diff[W-1] & ~overflow;
            err_cap  <= overflow;
            sreg     <= {8'd0, mag};
            cnt      <= CW'(W);
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sreg <= {sreg_adj[SW-2:0], 1'b0};
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          err   <= err_cap;
          sign  <= sign_cap;
          tens  <= err_cap ? 4'd0 : sreg[SW-1 -: 4];
          ones  <= err_cap ? 4'd0 : sreg[W+3 -: 4];
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/diff_to_bcd.md
DIFF_TO_BCD -- requirements
Module: diff_to_bcd

Interface
REQ-001 Parameter: W, default 6, operand width of the subtractor result; legal range 4..6, so magnitude is at most 32 and fits two BCD digits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request conversion of the current diff/overflow; sampled only in IDLE.
REQ-005 diff  input  W  two's-complement difference from the sixbitsub stage.
REQ-006 overflow  input  1  overflow flag from the sixbitsub stage.
REQ-007 busy  output  1  high while a conversion is in progress (SHIFT or DONE state).
REQ-008 done  output  1  one-cycle pulse when sign/tens/ones/err are updated.
REQ-009 sign  output  1  1 = result negative.
REQ-010 tens  output  4  BCD tens digit of |diff|.
REQ-011 ones  output  4  BCD ones digit of |diff|.
REQ-012 err  output  1  1 = captured overflow was set; digits forced to 0.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE; encodings are fixed in the shared header.
REQ-014 In IDLE with start=1, the block SHALL capture diff and overflow, load |diff| (W-bit unsigned; -2^(W-1) maps to 2^(W-1)) into the shift register, clear the BCD accumulator, set the bit counter to W, and enter SHIFT.
REQ-015 In SHIFT, each cycle SHALL add 3 to every BCD nibble >= 5, then shift the {BCD, binary} register left by one bit and decrement the counter; after W shifts the FSM SHALL enter DONE.
REQ-016 In DONE, the block SHALL register sign, tens, ones and err, assert done for exactly that cycle, and return to IDLE.
REQ-017 Latency: done SHALL be high in the cycle beginning W+1 rising edges after the edge that sampled start (7 for W=6).
REQ-018 start SHALL be ignored while busy=1, including in the DONE cycle; there is no queuing.
REQ-019 sign SHALL be 0 when diff=0 (no negative zero).
REQ-020 When the captured overflow=1: err=1, sign=0, tens=0, ones=0, with the same latency as a normal conversion.
REQ-021 sign, tens, ones and err SHALL hold their last values from DONE until the next DONE; diff changes outside the start-sampling edge SHALL have no effect.
REQ-022 tens SHALL never exceed 3 and ones SHALL never exceed 9.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, busy=0, done=0, sign=0, tens=0, ones=0, err=0, counter=0 and shift register=0.
REQ-024 rst asserted mid-conversion SHALL abort the conversion without a done pulse; the first start after rst deasserts SHALL convert normally.

Structure
REQ-025 State encodings and the BCD add-3 threshold/constant SHALL live in a shared `include header used by both RTL and bench.
REQ-026 The per-nibble correction SHALL be one combinational sub-module, bcd_add3 (4-bit in, 4-bit out), instantiated twice.

Verification
REQ-027 diff=6'b011111, overflow=0, start pulse -> done after 7 edges with sign=0, tens=3, ones=1, err=0.
REQ-028 diff=6'b100000 (-32) -> sign=1, tens=3, ones=2; diff=6'b111111 (-1) -> sign=1, tens=0, ones=1.
REQ-029 diff=0 -> sign=0, tens=0, ones=0; diff=6'd5 with overflow=1 -> err=1, sign=0, tens=0, ones=0.
REQ-030 start re-pulsed on cycles 2 and 7 of a conversion with a different diff -> exactly one done; outputs reflect the first diff only.
REQ-031 rst pulsed in SHIFT cycle 3 -> all outputs 0 at once, no done pulse; the next start with diff=6'd23 -> tens=2, ones=3.
REQ-032 Exhaustive sweep of all 64 diff values x overflow 0/1 through sixbitsub outputs, compared against a bench model.
